instr_fetch_unit: RTL

//  Fetch stage feeding the IF/ID pipeline register: generates the PC, issues in-order requests
//  to instruction memory, buffers responses with their PCs, and presents one instruction+PC per

---
 rtl/instr_fetch_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage in front of the IF/ID register.
// Generates the PC and issues in-order instruction-memory requests.
// Buffers the responses together with their PCs and presents one instruction+PC per cycle.
// Handles stall, redirect and dropping of stale in-flight responses.
// Optional build macro IFU_PERF_CNT_EN adds the perf_fetched / perf_bubbles counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    localparam int          PW      = $clog2(BUF_DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    // An all-zero word is not a legal instruction; present it as a NOP instead.
    function automatic logic [31:0] nop_if_zero(input logic [31:0] word);
        return (word == 32'h0) ? NOP : word;
    endfunction

    logic [31:0]   pc_q;
    logic [31:0]   buf_pc   [BUF_DEPTH];
    logic [31:0]   buf_data [BUF_DEPTH];
    logic [CW-1:0] alloc_ptr;
    logic [CW-1:0] fill_ptr;
    logic [CW-1:0] head_ptr;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] used;
    logic [CW-1:0] unfilled;
    logic [CW:0]   occupancy;
    logic [PW-1:0] head_idx;
    logic          head_filled;
    logic          grant;
    logic          fill;
    logic          drop;
    logic          pop;

    // Entries live between head and alloc; entries between head and fill hold data.
    assign used        = alloc_ptr - head_ptr;
    assign unfilled    = alloc_ptr - fill_ptr;
    assign head_filled = (fill_ptr != head_ptr);
    assign head_idx    = head_ptr[PW-1:0];
    // Slots owed to flushed requests still count, so a late stale response never overflows.
    assign occupancy   = {1'b0, used} + {1'b0, drop_cnt};

    assign imem_req  = !reset && !redirect && (occupancy < DEPTH_C);
    assign imem_addr = pc_q;

    assign grant = imem_req && imem_gnt;
    assign drop  = imem_rvalid && (drop_cnt != '0);
    assign fill  = imem_rvalid && (drop_cnt == '0) && (unfilled != '0) && !redirect;
    assign pop   = head_filled && !stall && !redirect;

    // Control state: PC, ring pointers and the count of stale responses still owed.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            drop_cnt  <= '0;
        end else if (redirect) begin
            // A response arriving in the redirect cycle belongs to the old stream and retires one owed slot.
            pc_q      <= {redirect_pc[31:2], 2'b00};
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            drop_cnt  <= drop_cnt + unfilled - {{(CW-1){1'b0}}, imem_rvalid};
        end else begin
            if (grant) begin
                alloc_ptr <= alloc_ptr + 1'b1;
                pc_q      <= pc_q + 32'd4;
            end
            if (fill) begin
                fill_ptr <= fill_ptr + 1'b1;
            end
            if (pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
            if (drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    // Buffer payload: PC captured at grant, instruction word captured at fill.
    always_ff @(posedge clk) begin
        if (grant) begin
            buf_pc[alloc_ptr[PW-1:0]] <= pc_q;
        end
        if (fill) begin
            buf_data[fill_ptr[PW-1:0]] <= imem_rdata;
        end
    end

    // Present the head entry, or a NOP bubble when there is nothing valid to show.
    always_comb begin
        instr_out = NOP;
        pc_out    = 32'h0;
        if (!reset && !redirect && head_filled) begin
            instr_out = nop_if_zero(buf_data[head_idx]);
            pc_out    = buf_pc[head_idx];
        end
    end

`ifdef IFU_PERF_CNT_EN
    // Performance counters: instructions handed to IF/ID and unstalled empty cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (!stall && !head_filled) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif

    // Every response must belong either to a flushed request or to an unfilled entry.
    a_rvalid_owned: assert property (@(posedge clk) disable iff (reset)
        !(imem_rvalid && (drop_cnt == '0) && (unfilled == '0)));

endmodule
